uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART serial receiver, 8N1 framing, LSB first; the receive-side counterpart to the team's baud-rate generator.
- Consumes a one-clk-wide oversampling enable `tick` at OVERSAMPLE × baud, provided by the baud tick source at the UART top.
- Recovers bytes from the `rx` line and presents each one through a valid/read handshake.
- Flags framing errors and overruns to the UART top/host logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8 supported).
- OVERSAMPLE, 16, tick pulses per bit period (must be even, >= 8).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  oversampling enable; one clk wide; OVERSAMPLE per bit period.
- rx  input  1  asynchronous serial input; idle high.
- rd_en  input  1  consumer acknowledges/pops data_out; sampled every clk.
- data_out  output  DATA_BITS  last correctly framed byte; reset 0.
- data_valid  output  1  level; high while an unread byte is held; reset 0.
- framing_err  output  1  one-clk pulse; stop bit sampled low; reset 0.
- overrun_err  output  1  one-clk pulse; new byte completed while data_valid=1 and no rd_en; reset 0.
- busy  output  1  high in any state other than IDLE; reset 0.

Behaviour:
- Interface is fixed: one clock `clk`; `reset` is asynchronous, active-low.
- Input sync: `rx` passes through 2 flops, both reset to 1. All logic uses the synchronised `rx_s` (2-clk latency).
- Counters:
  - tick_cnt: width clog2(OVERSAMPLE); advances only on clk edges where tick=1.
  - bit_cnt: width clog2(DATA_BITS+1).
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tick_cnt=0, bit_cnt=0.
  - rx_s==0 on a tick -> START, tick_cnt=0.
  - rx_s low without a tick is detected at the next tick.
- START:
  - On the tick where tick_cnt reaches OVERSAMPLE/2-1 (mid start bit), re-check rx_s.
  - rx_s==1 -> false start, back to IDLE; no flags.
  - rx_s==0 -> DATA, tick_cnt=0.
- DATA:
  - On the tick where tick_cnt==OVERSAMPLE-1, sample rx_s into shift[bit_cnt] (LSB first), tick_cnt=0, bit_cnt++.
  - After DATA_BITS samples -> STOP.
- STOP:
  - On the tick where tick_cnt==OVERSAMPLE-1, sample rx_s and go to IDLE in the same edge.
  - No wait for the end of the stop bit, so back-to-back frames are accepted.
  - rx_s==1: data_out<=shift, data_valid<=1 (next clk edge after the stop-sample tick).
  - If data_valid was already 1 and rd_en==0 in that cycle: also overrun_err=1 for one clk; data_out is overwritten with the new byte.
  - rx_s==0: framing_err=1 for one clk; data_out and data_valid unchanged; shifted byte discarded.
- Handshake:
  - rd_en && data_valid -> data_valid<=0 next edge.
  - rd_en while data_valid==0 is ignored.
  - rd_en in the same cycle as a good stop sample: new byte loads, data_valid stays 1, no overrun.
- tick=0 freezes all counters and state, except data_valid clear and output-pulse deassertion.
- Reset asserted mid-frame: every register returns to its reset value immediately; the partial byte is lost.
  - After release, the receiver waits in IDLE. If rx is low mid-frame at that point, a spurious start may be detected; this is acceptable.
- Latency: a byte is visible DATA_BITS+1.5 bit periods after the start edge, plus 2 clk for synchronisation, plus 1 clk.

Decomposition:
- Shared package `uart_pkg`:
  - rx state enum (IDLE/START/DATA/STOP).
  - Default OVERSAMPLE and DATA_BITS constants.
  - MID_TICK = OVERSAMPLE/2-1 and LAST_TICK = OVERSAMPLE-1.
  - Shared later by the transmitter.
- One sub-module: `uart_sync2`, a 2-flop synchroniser with reset value parameter (1 for rx).
- FSM, counters and output register stay in uart_rx.

Test Plan:
- Bench setup: tick every 4 clk (1 bit = 64 clk).
- Good frame: send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> data_valid rises about 1.5+8 bit periods after start edge, data_out=0xA5, no error pulses; rd_en one clk -> data_valid=0.
- False start: rx low for 16 clk (<half bit), then high -> stays/returns IDLE, busy drops, no data_valid, no flags.
- Framing error: send 0x3C with stop bit held 0 -> framing_err single-clk pulse, data_valid stays 0, data_out keeps previous value.
- Overrun: send 0x11 then 0x22 back-to-back without rd_en -> data_valid=1 throughout, overrun_err one pulse at second stop sample, data_out=0x22. Repeat with rd_en in the exact load cycle -> no overrun.
- Reset mid-frame: assert reset during bit 4 of 0xFF -> all outputs 0 asynchronously. After release and a clean frame 0x5A -> data_out=0x5A, data_valid=1.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions. Holds the receiver state encoding,
//               the default frame geometry and the tick positions inside a
//               bit period. The transmitter reuses the same package.
// Contents    : rx_state_t, DEF_DATA_BITS, DEF_OVERSAMPLE, MID_TICK,
//               LAST_TICK, mid_tick(), last_tick()
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    // Tick index at the middle of a bit and at the end of a bit period,
    // for the default oversampling ratio.
    localparam int MID_TICK  = DEF_OVERSAMPLE / 2 - 1;
    localparam int LAST_TICK = DEF_OVERSAMPLE - 1;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Same positions for a non-default oversampling ratio.
    function automatic int mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int last_tick(input int oversample);
        return oversample - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchroniser for a single asynchronous input.
//               Both flops load RESET_VAL while reset is asserted so the
//               synchronised output starts in the line's idle level.
// Ports       : clk   - system clock
//               reset - asynchronous active-low reset
//               d     - asynchronous input
//               q     - synchronised output (2 clk latency)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 8N1 style framing (DATA_BITS data bits, no
//               parity, one stop bit), LSB first. Oversamples the line with
//               an external tick at OVERSAMPLE x baud, validates the start
//               bit at its midpoint and samples each following bit one bit
//               period later. Received bytes are held behind a valid/read
//               handshake; framing errors and overruns are single-clk pulses.
// Ports       : clk         - system clock
//               reset       - asynchronous active-low reset
//               tick        - oversampling enable, one clk wide
//               rx          - asynchronous serial input, idle high
//               rd_en       - consumer pops data_out
//               data_out    - last correctly framed byte
//               data_valid  - unread byte held in data_out
//               framing_err - pulse: stop bit sampled low
//               overrun_err - pulse: byte completed over an unread byte
//               busy        - receiver is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] c_mid_tick  = TICK_W'(mid_tick(OVERSAMPLE));
    localparam logic [TICK_W-1:0] c_last_tick = TICK_W'(last_tick(OVERSAMPLE));
    localparam logic [BIT_W-1:0]  c_last_bit  = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            r_state;
    rx_state_t            w_next_state;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;

    logic w_mid_hit;
    logic w_last_hit;
    logic w_last_bit;
    logic w_data_sample;
    logic w_stop_sample;
    logic w_good_stop;
    logic w_bad_stop;

    // ------------------------------------------------------------------------
    // Input synchroniser; idle level of the line is high.
    // ------------------------------------------------------------------------
    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign w_mid_hit  = (r_tick_cnt == c_mid_tick);
    assign w_last_hit = (r_tick_cnt == c_last_tick);
    assign w_last_bit = (r_bit_cnt == c_last_bit);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic. Every transition is qualified by tick, so a
    // low rx_s seen between ticks is picked up at the following tick.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (tick) begin
            case (r_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        w_next_state = RX_START;
                    end
                end
                RX_START: begin
                    // Mid start bit: a high line means a glitch, not a frame.
                    if (w_mid_hit) begin
                        w_next_state = rx_s ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_last_hit && w_last_bit) begin
                        w_next_state = RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Leave at the stop sample instead of waiting out the
                    // stop bit, so a start bit right behind it is caught.
                    if (w_last_hit) begin
                        w_next_state = RX_IDLE;
                    end
                end
                default: begin
                    w_next_state = RX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        busy          = (r_state != RX_IDLE);
        w_data_sample = tick && (r_state == RX_DATA) && w_last_hit;
        w_stop_sample = tick && (r_state == RX_STOP) && w_last_hit;
        w_good_stop   = w_stop_sample && rx_s;
        w_bad_stop    = w_stop_sample && !rx_s;
    end

    // ------------------------------------------------------------------------
    // Tick/bit counters and data shifter. Frozen whenever tick is low.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (tick) begin
            case (r_state)
                RX_IDLE: begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                end
                RX_START: begin
                    // Restarting at the start-bit midpoint puts every later
                    // LAST_TICK sample in the middle of its bit.
                    r_tick_cnt <= w_mid_hit ? '0 : r_tick_cnt + 1'b1;
                end
                RX_DATA: begin
                    if (w_data_sample) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        // Shift in from the top: after DATA_BITS samples the
                        // first received bit sits at bit 0 (LSB first).
                        r_shift    <= {rx_s, r_shift[DATA_BITS-1:1]};
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    r_tick_cnt <= w_last_hit ? '0 : r_tick_cnt + 1'b1;
                end
                default: begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output register and handshake. A good stop sample wins over rd_en, so
    // a read in the load cycle pops the old byte and the new one stays valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            framing_err <= w_bad_stop;
            overrun_err <= w_good_stop && data_valid && !rd_en;
            if (w_good_stop) begin
                data_out   <= r_shift;
                data_valid <= 1'b1;
            end else if (rd_en) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Tick every 4 clk, so one
//               bit period is 64 clk. Frames are driven bit by bit and the
//               expected held byte, valid flag and error pulse counts come
//               from a frame-level model of the receiver's rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int DB      = 8;
    localparam int BIT_CLK = 64;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          tick  = 1'b0;
    logic          rx    = 1'b1;
    logic          rd_en = 1'b0;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          framing_err;
    logic          overrun_err;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Frame-level reference model state
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    int         exp_fe  = 0;
    int         exp_ov  = 0;

    // Observed event counters
    int fe_cnt      = 0;
    int ov_cnt      = 0;
    int long_pulse  = 0;
    int busy_rises  = 0;
    int valid_drops = 0;
    bit watch_valid = 1'b0;

    uart_rx #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .rx          (rx),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One-clk tick every 4 clk
    initial begin
        int tc;
        tc = 0;
        forever begin
            @(negedge clk);
            tc   = (tc + 1) % 4;
            tick = (tc == 0);
        end
    end

    // Output monitor, sampled 1 time unit after each rising edge
    initial begin
        logic pf, po, pb;
        pf = 1'b0;
        po = 1'b0;
        pb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (framing_err) begin
                fe_cnt++;
                if (pf) long_pulse++;
            end
            if (overrun_err) begin
                ov_cnt++;
                if (po) long_pulse++;
            end
            if (busy && !pb) busy_rises++;
            if (watch_valid && !data_valid) valid_drops++;
            pf = framing_err;
            po = overrun_err;
            pb = busy;
        end
    end

    // ---------------------------------------------------------------- helpers
    // Drives one full frame starting at the current negedge; ends at a negedge
    // with the line back high.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CLK) @(negedge clk);
        rx = 1'b1;
    endtask

    // Receiver rules at frame granularity
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic rd_at_load);
        if (stop) begin
            if (m_valid && !rd_at_load) exp_ov++;
            m_data  = b;
            m_valid = 1'b1;
        end else begin
            exp_fe++;
        end
    endtask

    task automatic do_read();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en   = 1'b0;
        m_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        checks++; if (framing_err !== 1'b0) begin failures++; $display("FAIL reset_framing_err: got %b expected 0", framing_err); end
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL reset_overrun_err: got %b expected 0", overrun_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_good_frame();
        int n;
        n = 0;
        @(negedge clk);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 1; i <= 800; i++) begin
                    @(posedge clk);
                    #1;
                    if (data_valid) begin
                        n = i;
                        break;
                    end
                end
            end
        join
        model_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        // 9.5 bit periods + 2 clk sync + 1 clk, plus up to 3 clk tick alignment
        checks++; if (n < 611 || n > 614) begin failures++; $display("FAIL good_latency: got %0d clk expected 611..614", n); end
        checks++; if (data_out !== m_data) begin failures++; $display("FAIL good_data_out: got %h expected %h", data_out, m_data); end
        checks++; if (data_valid !== m_valid) begin failures++; $display("FAIL good_data_valid: got %b expected %b", data_valid, m_valid); end
        checks++; if (fe_cnt !== exp_fe || ov_cnt !== exp_ov) begin failures++; $display("FAIL good_no_errors: got fe=%0d ov=%0d expected fe=%0d ov=%0d", fe_cnt, ov_cnt, exp_fe, exp_ov); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL good_busy_after: got %b expected 0", busy); end
        do_read();
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL good_read_clears: got %b expected 0", data_valid); end
        checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL good_read_keeps_data: got %h expected a5", data_out); end
    endtask

    task automatic test_false_start();
        int br;
        @(negedge clk);
        br = busy_rises;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (80) @(negedge clk);
        checks++; if (busy_rises - br !== 1) begin failures++; $display("FAIL false_start_detected: got %0d busy rises expected 1", busy_rises - br); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL false_start_busy: got %b expected 0", busy); end
        checks++; if (data_valid !== m_valid) begin failures++; $display("FAIL false_start_valid: got %b expected %b", data_valid, m_valid); end
        checks++; if (fe_cnt !== exp_fe || ov_cnt !== exp_ov) begin failures++; $display("FAIL false_start_flags: got fe=%0d ov=%0d expected fe=%0d ov=%0d", fe_cnt, ov_cnt, exp_fe, exp_ov); end
    endtask

    task automatic test_framing();
        @(negedge clk);
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        repeat (96) @(negedge clk);
        checks++; if (fe_cnt !== exp_fe) begin failures++; $display("FAIL framing_pulse_count: got %0d expected %0d", fe_cnt, exp_fe); end
        checks++; if (long_pulse !== 0) begin failures++; $display("FAIL framing_pulse_width: got %0d long pulses expected 0", long_pulse); end
        checks++; if (data_valid !== m_valid) begin failures++; $display("FAIL framing_valid: got %b expected %b", data_valid, m_valid); end
        checks++; if (data_out !== m_data) begin failures++; $display("FAIL framing_data_kept: got %h expected %h", data_out, m_data); end
        checks++; if (ov_cnt !== exp_ov || busy !== 1'b0) begin failures++; $display("FAIL framing_side: got ov=%0d busy=%b expected ov=%0d busy=0", ov_cnt, busy, exp_ov); end
    endtask

    task automatic test_overrun();
        int base;
        bit hit;
        // Back-to-back, never read
        @(negedge clk);
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        valid_drops = 0;
        watch_valid = 1'b1;
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        watch_valid = 1'b0;
        checks++; if (valid_drops !== 0) begin failures++; $display("FAIL overrun_valid_held: got %0d low cycles expected 0", valid_drops); end
        checks++; if (ov_cnt !== exp_ov) begin failures++; $display("FAIL overrun_pulse_count: got %0d expected %0d", ov_cnt, exp_ov); end
        checks++; if (long_pulse !== 0) begin failures++; $display("FAIL overrun_pulse_width: got %0d long pulses expected 0", long_pulse); end
        checks++; if (data_out !== m_data || data_valid !== m_valid) begin failures++; $display("FAIL overrun_data: got %h/%b expected %h/%b", data_out, data_valid, m_data, m_valid); end
        do_read();

        // Back-to-back with rd_en exactly in the second load cycle
        @(negedge clk);
        base = busy_rises;
        hit  = 1'b0;
        fork
            begin
                send_frame(8'h33, 1'b1);
                send_frame(8'h44, 1'b1);
            end
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(posedge clk);
                    #2;
                    if (busy_rises >= base + 2) begin
                        hit = 1'b1;
                        break;
                    end
                end
                if (hit) begin
                    // Stop sample lands 608 clk after the start-detect edge
                    repeat (607) @(posedge clk);
                    #1 rd_en = 1'b1;
                    @(posedge clk);
                    #1 rd_en = 1'b0;
                end
            end
        join
        model_frame(8'h33, 1'b1, 1'b0);
        model_frame(8'h44, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL rd_load_second_start: got %b expected 1 (timed out)", hit); end
        checks++; if (ov_cnt !== exp_ov) begin failures++; $display("FAIL rd_load_no_overrun: got %0d expected %0d", ov_cnt, exp_ov); end
        checks++; if (data_out !== m_data || data_valid !== m_valid) begin failures++; $display("FAIL rd_load_data: got %h/%b expected %h/%b", data_out, data_valid, m_data, m_valid); end
        do_read();
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (BIT_CLK * 5 + 30) @(negedge clk);
                #2 reset = 1'b0;
                #1;
                checks++; if (data_out !== 8'h00 || data_valid !== 1'b0) begin failures++; $display("FAIL midreset_data: got %h/%b expected 00/0", data_out, data_valid); end
                checks++; if (busy !== 1'b0 || framing_err !== 1'b0 || overrun_err !== 1'b0) begin failures++; $display("FAIL midreset_status: got busy=%b fe=%b ov=%b expected 0", busy, framing_err, overrun_err); end
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
        join
        m_data  = 8'h00;
        m_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (data_valid !== 1'b0 || data_out !== 8'h00) begin failures++; $display("FAIL midreset_partial_lost: got %h/%b expected 00/0", data_out, data_valid); end
        @(negedge clk);
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checks++; if (data_out !== m_data || data_valid !== m_valid) begin failures++; $display("FAIL after_reset_frame: got %h/%b expected %h/%b", data_out, data_valid, m_data, m_valid); end
        do_read();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop;
        for (int i = 0; i < 10; i++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) do_read();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            send_frame(b, stop);
            model_frame(b, stop, 1'b0);
            repeat (96) @(negedge clk);
            checks++; if (data_out !== m_data || data_valid !== m_valid) begin failures++; $display("FAIL random_%0d_data: got %h/%b expected %h/%b", i, data_out, data_valid, m_data, m_valid); end
            checks++; if (fe_cnt !== exp_fe || ov_cnt !== exp_ov) begin failures++; $display("FAIL random_%0d_errors: got fe=%0d ov=%0d expected fe=%0d ov=%0d", i, fe_cnt, ov_cnt, exp_fe, exp_ov); end
        end
        checks++; if (long_pulse !== 0 || busy !== 1'b0) begin failures++; $display("FAIL random_end_state: got long=%0d busy=%b expected 0/0", long_pulse, busy); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_false_start();
        test_framing();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
